// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the two-port ALU arbiter: FSM state encoding,
//   control-word bit positions, named op codes and an operand-steering
//   helper used by the behavioural ALU.
//   Control word layout: {u, op1, op0, zx, sw}.
package alu_arbiter_pkg;

   localparam int DATA_W = 16;
   localparam int CTRL_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Control-word bit positions
   localparam int CTRL_SW  = 0;
   localparam int CTRL_ZX  = 1;
   localparam int CTRL_OP0 = 2;
   localparam int CTRL_OP1 = 3;
   localparam int CTRL_U   = 4;

   // Named operations
   localparam logic [CTRL_W-1:0] OP_ADD = 5'b10000;
   localparam logic [CTRL_W-1:0] OP_SUB = 5'b11000;
   localparam logic [CTRL_W-1:0] OP_AND = 5'b00000;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } operands_t;

   // Swap first, then zero the (already swapped) X operand.
   function automatic operands_t alu_operands(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y,
                                              input logic [CTRL_W-1:0] ctrl);
      operands_t o;
      o.a = ctrl[CTRL_SW] ? y : x;
      o.b = ctrl[CTRL_SW] ? x : y;
      if (ctrl[CTRL_ZX]) o.a = '0;
      return o;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// GateLevelALU / BasicALU
//   Two implementations of the same 16-bit ALU; results are identical.
//   Ports: x, y (operands), ctrl ({u, op1, op0, zx, sw}), result.
//   Arithmetic (u=1): 00 X+Y, 01 X+1, 10 X-Y, 11 X-1, modulo 2^16.
//   Logic (u=0):      00 AND, 01 OR,  10 XOR, 11 NOT X.
module GateLevelALU
   import alu_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] result
);

   logic              sw, zx, op0, op1, u;
   logic [DATA_W-1:0] sx, sy, a, bb, sum, carry, logic_res;

   assign sw  = ctrl[CTRL_SW];
   assign zx  = ctrl[CTRL_ZX];
   assign op0 = ctrl[CTRL_OP0];
   assign op1 = ctrl[CTRL_OP1];
   assign u   = ctrl[CTRL_U];

   assign sx = (x & {DATA_W{~sw}}) | (y & {DATA_W{sw}});
   assign sy = (y & {DATA_W{~sw}}) | (x & {DATA_W{sw}});
   assign a  = sx & {DATA_W{~zx}};

   // One adder covers all four arithmetic ops:
   //   X+Y = a+y+0, X+1 = a+0+1, X-Y = a+~y+1, X-1 = a+FFFF+0
   assign bb       = ({DATA_W{~op0}} & (sy ^ {DATA_W{op1}})) | ({DATA_W{op0}} & {DATA_W{op1}});
   assign carry[0] = op0 ^ op1;

   for (genvar i = 0; i < DATA_W; i++) begin : g_fa
      assign sum[i] = a[i] ^ bb[i] ^ carry[i];
      if (i < DATA_W - 1) begin : g_c
         assign carry[i+1] = (a[i] & bb[i]) | (carry[i] & (a[i] ^ bb[i]));
      end
   end

   assign logic_res = ({DATA_W{~op1 & ~op0}} & (a & sy))
                    | ({DATA_W{~op1 &  op0}} & (a | sy))
                    | ({DATA_W{ op1 & ~op0}} & (a ^ sy))
                    | ({DATA_W{ op1 &  op0}} & ~a);

   assign result = u ? sum : logic_res;

endmodule

module BasicALU
   import alu_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] result
);

   operands_t o;

   always_comb begin
      o = alu_operands(x, y, ctrl);
      unique case ({ctrl[CTRL_U], ctrl[CTRL_OP1], ctrl[CTRL_OP0]})
         3'b100:  result = o.a + o.b;
         3'b101:  result = o.a + 16'd1;
         3'b110:  result = o.a - o.b;
         3'b111:  result = o.a - 16'd1;
         3'b000:  result = o.a & o.b;
         3'b001:  result = o.a | o.b;
         3'b010:  result = o.a ^ o.b;
         default: result = ~o.a;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_pick.sv
// RoundRobinPick2
//   Combinational two-way grant picker.
//   Ports: v0, v1 (requests), prio (port favoured on a tie),
//          g0, g1 (one-hot or zero grant).
module RoundRobinPick2 (
   input  logic v0,
   input  logic v1,
   input  logic prio,
   output logic g0,
   output logic g1
);

   assign g0 = v0 & (~v1 | ~prio);
   assign g1 = v1 & (~v0 | prio);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 16-bit ALU between two requesters. A request is granted in
//   IDLE (round-robin on a tie), operands are registered, the ALU result is
//   captured in EXEC, and held on the owner's response channel in RESP until
//   that port accepts it.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     reqN_valid/ready          request handshake (ready is combinational)
//     reqN_x, reqN_y, reqN_ctrl operands and control word {u,op1,op0,zx,sw}
//     respN_valid/ready         response handshake (valid is registered)
//     resp_data                 registered result, shared by both ports
//     busy                      high whenever the FSM is not in IDLE
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int USE_GATE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req0_x,
   input  logic [DATA_W-1:0] req0_y,
   input  logic [DATA_W-1:0] req1_x,
   input  logic [DATA_W-1:0] req1_y,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              resp0_valid,
   output logic              resp1_valid,
   input  logic              resp0_ready,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy
);

   state_t            state;
   logic              prio;
   logic              g0, g1;
   logic              owner_p0;
   logic [DATA_W-1:0] op_x_p0, op_y_p0;
   logic [CTRL_W-1:0] op_ctrl_p0;
   logic [DATA_W-1:0] alu_out;
   logic              owner_resp_ready;

   RoundRobinPick2 u_pick (
      .v0   (req0_valid),
      .v1   (req1_valid),
      .prio (prio),
      .g0   (g0),
      .g1   (g1)
   );

   // Ready is suppressed during reset so no port sees an acceptance that
   // the reset edge would discard.
   assign req0_ready = (state == IDLE) & g0 & ~rst;
   assign req1_ready = (state == IDLE) & g1 & ~rst;

   assign owner_resp_ready = owner_p0 ? resp1_ready : resp0_ready;

   if (USE_GATE_LEVEL != 0) begin : g_alu
      GateLevelALU u_alu (
         .x      (op_x_p0),
         .y      (op_y_p0),
         .ctrl   (op_ctrl_p0),
         .result (alu_out)
      );
   end else begin : g_alu
      BasicALU u_alu (
         .x      (op_x_p0),
         .y      (op_y_p0),
         .ctrl   (op_ctrl_p0),
         .result (alu_out)
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prio        <= 1'b0;
         owner_p0    <= 1'b0;
         op_x_p0     <= '0;
         op_y_p0     <= '0;
         op_ctrl_p0  <= '0;
         resp_data   <= '0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            // Grant and operand capture
            IDLE: begin
               if (g0 | g1) begin
                  op_x_p0    <= g1 ? req1_x    : req0_x;
                  op_y_p0    <= g1 ? req1_y    : req0_y;
                  op_ctrl_p0 <= g1 ? req1_ctrl : req0_ctrl;
                  owner_p0   <= g1;
                  state      <= EXEC;
                  busy       <= 1'b1;
               end
            end
            // ALU evaluation -> result register
            EXEC: begin
               resp_data   <= alu_out;
               resp0_valid <= ~owner_p0;
               resp1_valid <= owner_p0;
               state       <= RESP;
            end
            // Hold result until the owner takes it; the served port then
            // drops to lowest priority.
            RESP: begin
               if (owner_resp_ready) begin
                  prio        <= ~owner_p0;
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Drives two alu_arbiter instances (gate-level and behavioural ALU) with
//   the same stimulus. A transaction-level model predicts grants, busy and
//   response timing; expected results go into a scoreboard queue that a
//   separate monitor drains when a response appears.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        v   [2];
   logic [15:0] xs  [2];
   logic [15:0] ys  [2];
   logic [4:0]  cs  [2];
   logic        rr  [2];

   logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_busy;
   logic [15:0] a_data;
   logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_busy;
   logic [15:0] b_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.USE_GATE_LEVEL(1)) dut_gate (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req1_valid(v[1]),
      .req0_ready(a_rdy0), .req1_ready(a_rdy1),
      .req0_x(xs[0]), .req0_y(ys[0]), .req1_x(xs[1]), .req1_y(ys[1]),
      .req0_ctrl(cs[0]), .req1_ctrl(cs[1]),
      .resp0_valid(a_rv0), .resp1_valid(a_rv1),
      .resp0_ready(rr[0]), .resp1_ready(rr[1]),
      .resp_data(a_data), .busy(a_busy)
   );

   alu_arbiter #(.USE_GATE_LEVEL(0)) dut_basic (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req1_valid(v[1]),
      .req0_ready(b_rdy0), .req1_ready(b_rdy1),
      .req0_x(xs[0]), .req0_y(ys[0]), .req1_x(xs[1]), .req1_y(ys[1]),
      .req0_ctrl(cs[0]), .req1_ctrl(cs[1]),
      .resp0_valid(b_rv0), .resp1_valid(b_rv1),
      .resp0_ready(rr[0]), .resp1_ready(rr[1]),
      .resp_data(b_data), .busy(b_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference ALU straight from the control-word rules.
   function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [4:0] c);
      logic [15:0] a, b;
      a = x; b = y;
      if (c[0]) begin a = y; b = x; end
      if (c[1]) a = 16'h0000;
      case (c[4:2])
         3'b100:  return a + b;
         3'b101:  return a + 16'd1;
         3'b110:  return a - b;
         3'b111:  return a - 16'd1;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a ^ b;
         default: return ~a;
      endcase
   endfunction

   typedef struct {
      int          port;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   // Transaction model: idle/owned, who owns, cycles since grant, priority.
   bit m_idle  = 1'b1;
   bit m_prio  = 1'b0;
   int m_owner = 0;
   int m_age   = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("ready0_in_reset", a_rdy0, 1'b0);
            check("ready1_in_reset", a_rdy1, 1'b0);
            m_idle = 1'b1; m_prio = 1'b0; m_age = 0;
            sb.delete();
         end else begin
            bit g0, g1;
            if (!m_idle) m_age++;
            g0 = m_idle && v[0] && (!v[1] || !m_prio);
            g1 = m_idle && v[1] && (!v[0] ||  m_prio);
            check("req0_ready", a_rdy0, g0);
            check("req1_ready", a_rdy1, g1);
            check("busy", a_busy, !m_idle);
            check("resp0_valid", a_rv0, !m_idle && m_age >= 2 && m_owner == 0);
            check("resp1_valid", a_rv1, !m_idle && m_age >= 2 && m_owner == 1);
            check("gate_vs_basic", {a_rdy0, a_rdy1, a_rv0, a_rv1, a_busy, a_data},
                                   {b_rdy0, b_rdy1, b_rv0, b_rv1, b_busy, b_data});
            if (g0 || g1) begin
               int p;
               p = g1 ? 1 : 0;
               sb.push_back('{port: p, data: ref_alu(xs[p], ys[p], cs[p])});
               m_idle = 1'b0; m_owner = p; m_age = 0;
            end else if (!m_idle && m_age >= 2 && rr[m_owner]) begin
               m_idle = 1'b1;
               m_prio = (m_owner == 0);
            end
         end
      end
   end

   // Monitor: pop on each new response, then require the data to stay put.
   initial begin
      bit          pv [2];
      logic [15:0] held;
      pv[0] = 1'b0; pv[1] = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            logic vp;
            vp = (p == 0) ? a_rv0 : a_rv1;
            if (vp && !pv[p]) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_resp port=%0d actual=%h required=none", p, a_data);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("resp_port", p, e.port);
                  check("resp_data", a_data, e.data);
                  held = a_data;
               end
            end else if (vp) begin
               check("resp_hold", a_data, held);
            end
            pv[p] = vp;
         end
      end
   end

   bit rnd_rr = 1'b0;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rnd_rr) begin
            rr[0] = 1'($urandom_range(0, 1));
            rr[1] = 1'($urandom_range(0, 1));
         end
      end
   end

   function automatic logic rdy(input int p);
      return (p == 0) ? a_rdy0 : a_rdy1;
   endfunction

   // Issue n operations on port p, keeping valid high between them unless
   // randomised gaps are requested.
   task automatic send(input int p, input int n, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0] c, input bit rnd);
      for (int k = 0; k < n; k++) begin
         int t;
         xs[p] = rnd ? 16'($urandom) : x;
         ys[p] = rnd ? 16'($urandom) : y;
         cs[p] = rnd ? 5'($urandom)  : c;
         v[p]  = 1'b1;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!rdy(p) && t < 100);
         check("accept_in_time", (t < 100), 1'b1);
         @(posedge clk); #1;
         if (rnd) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
               v[p] = 1'b0;
               repeat (gap) @(posedge clk);
               #1;
            end
         end
      end
      v[p] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(m_idle && sb.size() == 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_in_time", (t < 200), 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b0; xs[p] = '0; ys[p] = '0; cs[p] = '0; rr[p] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check("reset_busy", a_busy, 1'b0);
      check("reset_data", a_data, 16'h0000);
      check("reset_rv", {a_rv0, a_rv1}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single ADD on port 0
      send(0, 1, 16'd7, 16'd4, OP_ADD, 1'b0);
      wait_idle();

      // Simultaneous requests: port 0 SUB, port 1 SUB with swap
      fork
         send(0, 1, 16'd7, 16'd4, OP_SUB, 1'b0);
         send(1, 1, 16'd7, 16'd4, 5'b11001, 1'b0);
      join
      wait_idle();

      // Port 1 response back-pressured for 5 cycles while port 0 waits
      rr[1] = 1'b0;
      fork
         send(1, 1, 16'd7, 16'd4, 5'b11011, 1'b0);
         begin
            @(posedge clk); #1;
            send(0, 1, 16'd3, 16'd5, OP_ADD, 1'b0);
         end
         begin
            int t;
            t = 0;
            while (!a_rv1 && t < 50) begin
               @(negedge clk);
               t++;
            end
            check("resp1_appears", a_rv1, 1'b1);
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
            rr[1] = 1'b1;
         end
      join
      wait_idle();

      // Continuous requests on both ports: grants must alternate
      fork
         send(0, 3, 16'hFFFF, 16'hFFFF, OP_AND, 1'b0);
         send(1, 3, 16'hFFFF, 16'hFFFF, OP_AND, 1'b0);
      join
      wait_idle();

      // Reset during EXEC drops the operation
      xs[0] = 16'd1; ys[0] = 16'hFFFF; cs[0] = OP_ADD; v[0] = 1'b1;
      begin
         int t;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!a_rdy0 && t < 50);
         check("reset_op_accept", a_rdy0, 1'b1);
      end
      @(posedge clk); #1;
      v[0] = 1'b0;
      rst  = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midreset_busy", a_busy, 1'b0);
      check("midreset_data", a_data, 16'h0000);
      check("midreset_rv", {a_rv0, a_rv1}, 2'b00);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;

      // Randomised traffic with random response back-pressure
      rnd_rr = 1'b1;
      fork
         send(0, 40, 16'h0, 16'h0, 5'h0, 1'b1);
         send(1, 40, 16'h0, 16'h0, 5'h0, 1'b1);
      join
      rnd_rr = 1'b0;
      rr[0] = 1'b1; rr[1] = 1'b1;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
